// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: round-robin with bounded
// bursts, address checking, and registered one-cycle read responses per port.
module dm_arbiter #(
  parameter int DM_WORDS  = 1024,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        MemWr,
  input  logic [31:0] dm_rdata
);

  localparam int               CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [31:0]      WORDS_L = 32'(DM_WORDS);

  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < WORDS_L);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic            same);
    if (!same) return CNT_W'(1);
    return (c < CNT_MAX) ? c + CNT_W'(1) : CNT_MAX;
  endfunction

  logic             last;
  logic [CNT_W-1:0] cnt;

  logic             any_p0;
  logic             sel_p0;
  logic             we_p0;
  logic             ok_p0;
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [31:0]      rdata_p0;

  // Stage p0: arbitration and DM drive within the grant cycle.
  // cnt==0 only right after reset; the contest then goes to !last so port 0 wins first.
  always_comb begin
    any_p0 = 1'b0;
    sel_p0 = 1'b0;
    if (reset) begin
      if (p0_req && p1_req) begin
        any_p0 = 1'b1;
        sel_p0 = ((cnt != '0) && (cnt < CNT_MAX)) ? last : ~last;
      end else if (p0_req) begin
        any_p0 = 1'b1;
        sel_p0 = 1'b0;
      end else if (p1_req) begin
        any_p0 = 1'b1;
        sel_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    we_p0    = 1'b0;
    addr_p0  = '0;
    wdata_p0 = '0;
    if (any_p0) begin
      we_p0    = sel_p0 ? p1_we    : p0_we;
      addr_p0  = sel_p0 ? p1_addr  : p0_addr;
      wdata_p0 = sel_p0 ? p1_wdata : p0_wdata;
    end
    ok_p0    = addr_ok(addr_p0);
    rdata_p0 = (!we_p0 && ok_p0) ? dm_rdata : '0;
  end

  assign p0_gnt  = any_p0 & ~sel_p0;
  assign p1_gnt  = any_p0 & sel_p0;
  assign MemAddr = addr_p0;
  assign MemData = wdata_p0;
  assign MemWr   = any_p0 & we_p0 & ok_p0;

  // Stage p1: registered response on the granted port; the idle port holds rdata/err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last      <= 1'b1;
      cnt       <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt;
      p1_rvalid <= p1_gnt;
      if (any_p0) begin
        cnt  <= cnt_next(cnt, sel_p0 == last);
        last <= sel_p0;
      end
      if (p0_gnt) begin
        p0_rdata <= rdata_p0;
        p0_err   <= ~ok_p0;
      end
      if (p1_gnt) begin
        p1_rdata <= rdata_p0;
        p1_err   <= ~ok_p0;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations plus a random
// phase, all compared each cycle against a transaction-level model of the arbiter.
module tb_dm_arbiter;

  localparam int DM_WORDS  = 1024;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] MemAddr, MemData, dm_rdata;
  logic        MemWr;

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.DM_WORDS(DM_WORDS), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .MemAddr(MemAddr), .MemData(MemData), .MemWr(MemWr), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // The data memory the arbiter is attached to.
  logic [31:0] dm [DM_WORDS];
  assign dm_rdata = dm[MemAddr[11:2]];
  always @(posedge clk) if (MemWr) dm[MemAddr[11:2]] <= MemData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long its run is, a shadow memory,
  // and the response each port should present after the next edge.
  logic [31:0] mref [DM_WORDS];
  bit          mdl_on = 0;
  int          m_owner = 1;
  int          m_run = 0;
  logic        e_rv [2];
  logic [31:0] e_rd [2];
  logic        e_err [2];

  always @(negedge clk) begin
    int          g;
    logic [31:0] a, wd;
    logic        we, ok;
    g  = -1;
    a  = '0;
    wd = '0;
    we = 1'b0;
    ok = 1'b0;
    if (reset === 1'b1) begin
      if (p0_req && p1_req) g = (m_run > 0 && m_run < BURST_MAX) ? m_owner : 1 - m_owner;
      else if (p0_req)      g = 0;
      else if (p1_req)      g = 1;
    end
    if (g >= 0) begin
      a  = (g == 0) ? p0_addr  : p1_addr;
      wd = (g == 0) ? p0_wdata : p1_wdata;
      we = (g == 0) ? p0_we    : p1_we;
      ok = (a % 4 == 0) && (a / 4 < DM_WORDS);
    end
    if (mdl_on) begin
      chk("p0_gnt", 32'(p0_gnt), 32'(g == 0));
      chk("p1_gnt", 32'(p1_gnt), 32'(g == 1));
      chk("MemWr", 32'(MemWr), 32'(we && ok));
      chk("MemAddr", MemAddr, a);
      chk("MemData", MemData, wd);
      chk("p0_rvalid", 32'(p0_rvalid), 32'(e_rv[0]));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(e_rv[1]));
      chk("p0_rdata", p0_rdata, e_rd[0]);
      chk("p1_rdata", p1_rdata, e_rd[1]);
      chk("p0_err", 32'(p0_err), 32'(e_err[0]));
      chk("p1_err", 32'(p1_err), 32'(e_err[1]));
    end
    if (reset !== 1'b1) begin
      m_owner = 1;
      m_run   = 0;
      for (int i = 0; i < 2; i++) begin
        e_rv[i]  = 1'b0;
        e_rd[i]  = '0;
        e_err[i] = 1'b0;
      end
      mdl_on = 1;
    end else begin
      e_rv[0] = (g == 0);
      e_rv[1] = (g == 1);
      if (g >= 0) begin
        e_rd[g]  = (!we && ok) ? mref[a / 4] : 32'h0;
        e_err[g] = !ok;
        if (we && ok) mref[a / 4] = wd;
        m_run   = (g == m_owner) ? ((m_run < BURST_MAX) ? m_run + 1 : BURST_MAX) : 1;
        m_owner = g;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic req, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h1000 + 32'($urandom_range(0, 63)) * 4;
    if (r == 1) return 32'($urandom_range(0, 63));
    return 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    for (int i = 0; i < DM_WORDS; i++) begin
      dm[i]   = '0;
      mref[i] = '0;
    end
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    cyc(); cyc();

    // Store then load on port 0.
    reset = 1'b1;
    drv(0, 1, 1, 32'h4, 32'h2);
    @(negedge clk);
    chk("t1 gnt", 32'(p0_gnt), 32'h1);
    chk("t1 memwr", 32'(MemWr), 32'h1);
    cyc();
    drv(0, 1, 0, 32'h4, 32'h0);
    @(negedge clk);
    chk("t1 st rvalid", 32'(p0_rvalid), 32'h1);
    chk("t1 st err", 32'(p0_err), 32'h0);
    cyc();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1 ld rdata", p0_rdata, 32'h2);

    // Both ports contend from reset: bursts of four, port 0 first.
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    drv(0, 1, 0, 32'h0, 0);
    drv(1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2 p0 gnt", 32'(p0_gnt), 32'(((i / 4) % 2) == 0));
      chk("t2 p1 gnt", 32'(p1_gnt), 32'(((i / 4) % 2) == 1));
      cyc();
    end

    // Port 1 alone is never forced to yield.
    drv(0, 0, 0, 0, 0);
    drv(1, 1, 0, 32'h4, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3 p1 gnt", 32'(p1_gnt), 32'h1);
      if (i > 0) chk("t3 p1 rvalid", 32'(p1_rvalid), 32'h1);
      cyc();
    end
    drv(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3 last rvalid", 32'(p1_rvalid), 32'h1);
    chk("t3 last rdata", p1_rdata, 32'h2);
    cyc();
    @(negedge clk);
    chk("t3 idle rvalid", 32'(p1_rvalid), 32'h0);

    // Misaligned store and out-of-range load are rejected.
    drv(0, 1, 1, 32'h6, 32'hBAD);
    @(negedge clk);
    chk("t4 misaligned memwr", 32'(MemWr), 32'h0);
    cyc();
    drv(0, 0, 0, 0, 0);
    drv(1, 1, 0, 32'h1000, 0);
    @(negedge clk);
    chk("t4 p0 err", 32'(p0_err), 32'h1);
    chk("t4 p0 rdata", p0_rdata, 32'h0);
    cyc();
    drv(1, 0, 0, 0, 0);
    drv(0, 1, 0, 32'h4, 0);
    @(negedge clk);
    chk("t4 p1 err", 32'(p1_err), 32'h1);
    chk("t4 p1 rdata", p1_rdata, 32'h0);
    cyc();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 readback", p0_rdata, 32'h2);
    chk("t4 readback err", 32'(p0_err), 32'h0);

    // A request presented while reset is held has no effect.
    cyc();
    reset = 1'b0;
    drv(0, 1, 1, 32'h8, 32'hDEAD);
    @(negedge clk);
    chk("t5 gnt in reset", 32'(p0_gnt), 32'h0);
    chk("t5 memwr in reset", 32'(MemWr), 32'h0);
    cyc();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5 no rvalid", 32'(p0_rvalid), 32'h0);
    cyc();
    drv(0, 1, 0, 32'h8, 0);
    cyc();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5 readback", p0_rdata, 32'h0);

    // Write on port 1 then immediate read on port 0.
    cyc();
    drv(1, 1, 1, 32'hC, 32'h55);
    cyc();
    drv(1, 0, 0, 0, 0);
    drv(0, 1, 0, 32'hC, 0);
    cyc();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6 raw", p0_rdata, 32'h55);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset = ($urandom_range(0, 99) != 0);
      drv(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      drv(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    end
    cyc();
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
